// File: rtl/aes_regfile_ctrl_if.sv
// rtl/aes_regfile_ctrl_if.sv - decode, AES-core and register-file write-port signals of aes_regfile_ctrl
interface aes_regfile_ctrl_if;
  logic         in_aes_start;
  logic [127:0] in_cipherkey;
  logic [127:0] in_state;
  logic [127:0] out_aes_key;
  logic [127:0] out_aes_state;
  logic         out_aes_start;
  logic         in_aes_done;
  logic [127:0] in_aes_result;
  logic         in_wb_regWrite;
  logic [4:0]   in_wb_addr;
  logic [31:0]  in_wb_data;
  logic         out_regWrite;
  logic [4:0]   out_write_addr;
  logic [31:0]  out_write_data;
  logic         out_busy;
  logic         out_stall;
  logic         out_done;
  logic         out_error;

  modport slave (
    input  in_aes_start, in_cipherkey, in_state, in_aes_done, in_aes_result,
           in_wb_regWrite, in_wb_addr, in_wb_data,
    output out_aes_key, out_aes_state, out_aes_start, out_regWrite, out_write_addr,
           out_write_data, out_busy, out_stall, out_done, out_error
  );

  modport master (
    output in_aes_start, in_cipherkey, in_state, in_aes_done, in_aes_result,
           in_wb_regWrite, in_wb_addr, in_wb_data,
    input  out_aes_key, out_aes_state, out_aes_start, out_regWrite, out_write_addr,
           out_write_data, out_busy, out_stall, out_done, out_error
  );
endinterface

// File: rtl/aes_regfile_ctrl.sv
// rtl/aes_regfile_ctrl.sv - sequences one AES-128 op between regfile and core; optional WAIT watchdog under AES_TIMEOUT_EN
module aes_regfile_ctrl #(
  parameter int unsigned RESULT_BASE = 20
`ifdef AES_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 64
`endif
) (
  input logic               in_clk,
  input logic               in_rst,
  aes_regfile_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic [4:0] BASE = 5'(RESULT_BASE);

  state_t       state_q;
  logic [1:0]   idx_q;
  logic [127:0] key_q;
  logic [127:0] st_q;
  logic [127:0] result_q;
  logic         start_q;
  logic         done_q;

`ifdef AES_TIMEOUT_EN
  localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;
`endif

  logic        wb_pending;
  logic        res_wr;
  logic [31:0] res_word;

  // Address-0 pipeline writes are harmless, so they never stall the result drain.
  assign wb_pending = bus.in_wb_regWrite && (bus.in_wb_addr != 5'd0);
  assign res_wr     = (state_q == S_WRITE) && !wb_pending && !in_rst;

  always_comb begin
    res_word = result_q[127:96];
    case (idx_q)
      2'd0:    res_word = result_q[127:96];
      2'd1:    res_word = result_q[95:64];
      2'd2:    res_word = result_q[63:32];
      default: res_word = result_q[31:0];
    endcase
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q  <= S_IDLE;
      idx_q    <= 2'd0;
      key_q    <= '0;
      st_q     <= '0;
      result_q <= '0;
      start_q  <= 1'b0;
      done_q   <= 1'b0;
`ifdef AES_TIMEOUT_EN
      cnt_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      start_q <= 1'b0;
      done_q  <= 1'b0;
`ifdef AES_TIMEOUT_EN
      err_q   <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (bus.in_aes_start) begin
            key_q   <= bus.in_cipherkey;
            st_q    <= bus.in_state;
            start_q <= 1'b1;
            state_q <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          state_q <= S_WAIT;
`ifdef AES_TIMEOUT_EN
          cnt_q   <= '0;
`endif
        end
        S_WAIT: begin
          if (bus.in_aes_done) begin
            result_q <= bus.in_aes_result;
            idx_q    <= 2'd0;
            state_q  <= S_WRITE;
          end
`ifdef AES_TIMEOUT_EN
          else if (cnt_q == CNT_LAST) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        S_WRITE: begin
          if (!wb_pending) begin
            idx_q <= idx_q + 2'd1;
            if (idx_q == 2'd3) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.out_aes_key    = key_q;
  assign bus.out_aes_state  = st_q;
  assign bus.out_aes_start  = start_q;
  assign bus.out_done       = done_q;
  assign bus.out_busy       = (state_q != S_IDLE);
  assign bus.out_stall      = (state_q != S_IDLE) && bus.in_aes_start;
  assign bus.out_regWrite   = res_wr ? 1'b1 : bus.in_wb_regWrite;
  assign bus.out_write_addr = res_wr ? (BASE + {3'b000, idx_q}) : bus.in_wb_addr;
  assign bus.out_write_data = res_wr ? res_word : bus.in_wb_data;
`ifdef AES_TIMEOUT_EN
  assign bus.out_error      = err_q;
`else
  assign bus.out_error      = 1'b0;
`endif

endmodule

// File: doc/aes_regfile_ctrl.md
Name: aes_regfile_ctrl

Overview:
Sequences one AES-128 operation between the register file and the AES core.
- On an AES instruction, captures the cipher key (regs 16-19) and the state (regs 20-23), launches the core and waits for completion.
- Writes the 128-bit result back into regs RESULT_BASE..RESULT_BASE+3 through the single register-file write port.
- Shares that write port with the pipeline writeback stage; the pipeline always wins.

Parameters:
RESULT_BASE, 20, first destination register of the result; words go to RESULT_BASE..RESULT_BASE+3; legal range 1..28.
TIMEOUT_CYCLES, 64, watchdog limit in WAIT; only used when AES_TIMEOUT_EN is defined.

Ports:
in_clk  input  1  clock; all state updates on posedge.
in_rst  input  1  synchronous reset, active-high.
in_aes_start  input  1  one-cycle request from decode (AES instruction).
in_cipherkey  input  128  regfile key view, {r16,r17,r18,r19}.
in_state  input  128  regfile state view, {r20,r21,r22,r23}.
out_aes_key  output  128  key held for the core.
out_aes_state  output  128  state held for the core.
out_aes_start  output  1  one-cycle launch pulse to the core.
in_aes_done  input  1  core completion pulse.
in_aes_result  input  128  core result, valid when in_aes_done=1.
in_wb_regWrite  input  1  pipeline writeback enable.
in_wb_addr  input  5  pipeline writeback address.
in_wb_data  input  32  pipeline writeback data.
out_regWrite  output  1  regfile write enable (arbitrated).
out_write_addr  output  5  regfile write address.
out_write_data  output  32  regfile write data.
out_busy  output  1  high in every state except IDLE.
out_stall  output  1  combinational, = out_busy & in_aes_start; the pipeline must hold the instruction.
out_done  output  1  one-cycle pulse when an operation ends.
out_error  output  1  one-cycle pulse on timeout; tied 0 when the feature is off.

Behaviour:
- States: IDLE, LAUNCH, WAIT, WRITE, DONE. A 2-bit word index idx is used in WRITE.
- Reset, when in_rst=1 at a posedge:
  - State goes to IDLE; idx=0.
  - Registered outputs clear: key/state/result holds, out_aes_start, out_done, out_error.
  - Applies mid-operation too: an in-flight result is discarded and no further writes occur.
- IDLE:
  - If in_aes_start=1, latch in_cipherkey/in_state into out_aes_key/out_aes_state and go to LAUNCH.
  - in_aes_done is ignored.
- LAUNCH: out_aes_start=1 for exactly this one cycle, then go to WAIT.
- WAIT:
  - If in_aes_done=1, latch in_aes_result, set idx=0 and go to WRITE.
  - Otherwise stay in WAIT.
  - in_aes_done in any other state is ignored.
- WRITE, write-port arbitration each cycle:
  - Pipeline write pending (in_wb_regWrite=1 and in_wb_addr!=0): pass in_wb_* through unchanged; idx holds.
  - Otherwise drive out_regWrite=1, out_write_addr=RESULT_BASE+idx, out_write_data=word idx, then idx++.
  - Word order is MSW first: idx0 = result[127:96], idx3 = result[31:0].
  - After idx=3 is written, go to DONE.
  - Minimum 4 cycles in WRITE, plus one extra cycle per pipeline write.
- DONE: out_done=1 for one cycle, then go to IDLE. A new in_aes_start is accepted in the following IDLE cycle.
- Write port outside WRITE: out_regWrite/out_write_addr/out_write_data = in_wb_* pass-through, combinational with no added latency.
- Write to $0: a pipeline write with addr 0 is forwarded unchanged; the regfile discards it. It does not block a result write.
- in_aes_start while busy: not latched; out_stall=1 in that cycle.
- Pipeline write to the same register as a pending result word: the pipeline write lands first and the later result word overwrites it. This ordering is intended.
- Latency: start accepted at cycle T, out_aes_start at T+1, WAIT entered at T+2. With done at cycle D and no contention, writes occur at D+1..D+4 and out_done at D+5.

Optional Feature:
AES_TIMEOUT_EN
- Defined:
  - An 8-bit-or-wider counter clears on entering WAIT and increments each cycle in WAIT.
  - If it reaches TIMEOUT_CYCLES with no in_aes_done, go to DONE with out_error=1 alongside out_done, and perform no writeback.
  - A done arriving in the same cycle as the limit takes priority; it counts as a normal completion.
- Not defined: WAIT persists until in_aes_done; out_error is constant 0 and no counter is present.

Test Plan:
- Basic operation: reset, then key=0x000102..0F, state=0x00112233..FF; start pulse; core returns 0x69C4E0D8_6A7B0430_D8CDB780_70B4C55A 10 cycles after launch. Required: writes r20=69C4E0D8, r21=6A7B0430, r22=D8CDB780, r23=70B4C55A on 4 consecutive cycles; out_done pulses 1 cycle later; out_aes_start is high exactly one cycle.
- Contention: during WRITE, a pipeline write r5=0xDEADBEEF on cycles 1 and 2. Required: both pass through unchanged; result words are delayed 2 cycles and still land in order at r20..r23; out_done is 2 cycles later than the basic case.
- Busy start: in_aes_start asserted in WAIT. Required: out_stall=1 that cycle; the latched key is unchanged; no second launch.
- Reset mid-operation: in_rst in WRITE after 2 words. Required: next cycle all outputs 0 and state IDLE; r22/r23 are not written; write port returns to pass-through.
- Idle pass-through: no AES activity; a pipeline write r7=0x12345678. Required: out_* mirrors it in the same cycle; a spurious in_aes_done in IDLE is ignored.
- Timeout (AES_TIMEOUT_EN defined): launch and never send done. Required: out_done and out_error both pulse at cycle 64 of WAIT, with no regfile writes. A second run with done exactly at cycle 64 completes normally with out_error=0.
